// File: rtl/bram_word_uart_streamer.sv
// Streams WORD_COUNT 32-bit words from a registered-output BRAM to uart_transmit,
// most significant byte first, one trigger per busy low->high->low cycle.
//
// state   | meaning
// IDLE    | waiting for start_in with enable_in high
// FETCH   | address held for READ_LATENCY cycles, then word captured
// SEND    | waiting for uart idle, then present top byte and pulse trigger
// GUARD   | trigger cleared; busy ignored while uart_transmit raises it
// WAIT_TX | waiting for the byte in flight to finish
// NEXT    | advance to the next address or finish the run
module bram_word_uart_streamer #(
    parameter int ADDR_WIDTH   = 15,
    parameter int WORD_COUNT   = 25251,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    input  logic                  start_in,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    input  logic [31:0]           bram_data_in,
    input  logic                  uart_busy_in,
    output logic [7:0]            uart_byte_out,
    output logic                  uart_trigger_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [ADDR_WIDTH-1:0] words_sent_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(WORD_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(WORD_COUNT);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [1:0]            LAT_LAST   = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        GUARD,
        WAIT_TX,
        NEXT
    } state_t;

    state_t      state;
    logic [31:0] word_reg;
    logic [1:0]  byte_idx;
    logic [1:0]  lat_cnt;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= IDLE;
            word_reg         <= '0;
            byte_idx         <= '0;
            lat_cnt          <= '0;
            bram_addr_out    <= '0;
            uart_byte_out    <= '0;
            uart_trigger_out <= 1'b0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            words_sent_out   <= '0;
        end else begin
            done_out         <= 1'b0;
            uart_trigger_out <= 1'b0;
            if (state != IDLE && !enable_in) begin
                // Abort: a byte already handed to the uart finishes on its own.
                state         <= IDLE;
                busy_out      <= 1'b0;
                bram_addr_out <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_in && enable_in) begin
                            bram_addr_out  <= '0;
                            words_sent_out <= '0;
                            lat_cnt        <= '0;
                            busy_out       <= 1'b1;
                            state          <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (lat_cnt == LAT_LAST) begin
                            word_reg <= bram_data_in;
                            byte_idx <= '0;
                            state    <= SEND;
                        end else begin
                            lat_cnt <= lat_cnt + 2'd1;
                        end
                    end
                    SEND: begin
                        if (!uart_busy_in) begin
                            uart_byte_out    <= word_reg[31:24];
                            uart_trigger_out <= 1'b1;
                            state            <= GUARD;
                        end
                    end
                    GUARD: begin
                        // uart_transmit only raises busy the cycle after trigger.
                        state <= WAIT_TX;
                    end
                    WAIT_TX: begin
                        if (!uart_busy_in) begin
                            if (byte_idx != 2'd3) begin
                                word_reg <= {word_reg[23:0], 8'h00};
                                byte_idx <= byte_idx + 2'd1;
                                state    <= SEND;
                            end else begin
                                if (words_sent_out != WORD_LIMIT) begin
                                    words_sent_out <= words_sent_out + ADDR_ONE;
                                end
                                state <= NEXT;
                            end
                        end
                    end
                    NEXT: begin
                        if (bram_addr_out == LAST_ADDR) begin
                            done_out      <= 1'b1;
                            bram_addr_out <= '0;
                            busy_out      <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            bram_addr_out <= bram_addr_out + ADDR_ONE;
                            lat_cnt       <= '0;
                            state         <= FETCH;
                        end
                    end
                    default: begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bram_word_uart_streamer.sv
// Scoreboard bench: expected bytes are queued from the memory contents when a run
// starts; a negedge monitor pops and checks every trigger the streamer issues.
module tb_bram_word_uart_streamer;

    localparam int AW = 15;
    localparam int WC = 3;
    localparam int RL = 2;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          enable_in = 1'b0;
    logic          start_in = 1'b0;
    logic [AW-1:0] bram_addr_out;
    logic [31:0]   bram_data_in = '0;
    logic          uart_busy_in = 1'b0;
    logic [7:0]    uart_byte_out;
    logic          uart_trigger_out;
    logic          busy_out;
    logic          done_out;
    logic [AW-1:0] words_sent_out;

    bram_word_uart_streamer #(
        .ADDR_WIDTH  (AW),
        .WORD_COUNT  (WC),
        .READ_LATENCY(RL)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .start_in        (start_in),
        .bram_addr_out   (bram_addr_out),
        .bram_data_in    (bram_data_in),
        .uart_busy_in    (uart_busy_in),
        .uart_byte_out   (uart_byte_out),
        .uart_trigger_out(uart_trigger_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .words_sent_out  (words_sent_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        int         word;
        int         idx;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem[WC];
    int          hold_tab[12];
    int          run_seq = 0;
    int          done_cnt = 0;
    int          trig_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // BRAM: data for an address is sampled valid READ_LATENCY edges after the address edge.
    always @(posedge clk_in)
        bram_data_in <= (bram_addr_out < AW'(WC)) ? mem[bram_addr_out[1:0]] : 32'hDEADBEEF;

    // UART: busy rises the cycle after trigger and stays high hold_tab[n] cycles.
    int busy_left = 0;
    int seen_seq = -1;
    int tx_idx = 0;
    always @(posedge clk_in) begin
        if (uart_trigger_out) begin
            seen_seq     <= run_seq;
            tx_idx       <= (seen_seq != run_seq) ? 1 : tx_idx + 1;
            busy_left    <= hold_tab[(seen_seq != run_seq) ? 0 : (tx_idx % 12)];
            uart_busy_in <= 1'b1;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            busy_left    <= 0;
            uart_busy_in <= 1'b0;
        end
    end

    // Monitor
    initial begin
        int   mcyc;
        int   fall_at;
        logic busy_prev;
        exp_t e;
        mcyc = 0;
        fall_at = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk_in);
            mcyc++;
            if (busy_prev && !uart_busy_in) fall_at = mcyc;
            busy_prev = uart_busy_in;
            check("addr_range", longint'(bram_addr_out < AW'(WC)), 1);
            if (uart_trigger_out) begin
                trig_total++;
                check("trig_while_busy", uart_busy_in, 0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_trigger: byte 0x%0h with nothing expected", uart_byte_out);
                end else begin
                    e = sb_q.pop_front();
                    check("byte", uart_byte_out, e.b);
                    check("addr_at_byte", bram_addr_out, e.word);
                    if (e.idx != 0) check("gap_in_word", mcyc - fall_at, 2);
                    else if (e.word != 0) check("gap_next_word", mcyc - fall_at, RL + 3);
                end
            end
            if (done_out) begin
                done_cnt++;
                check("done_all_bytes", sb_q.size(), 0);
            end
        end
    end

    task automatic push_run();
        exp_t e;
        for (int w = 0; w < WC; w++) begin
            for (int k = 0; k < 4; k++) begin
                e.b    = 8'(mem[w] >> (8 * (3 - k)));
                e.word = w;
                e.idx  = k;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic wait_uart_idle();
        int n = 0;
        while (uart_busy_in && n < 1000) begin
            @(negedge clk_in);
            n++;
        end
        check("uart_idle_timeout", uart_busy_in, 0);
    endtask

    // Starts a run and returns at the negedge showing the first trigger.
    task automatic start_run();
        int n = 0;
        run_seq++;
        push_run();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        while (!uart_trigger_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        check("first_trig_latency", n, RL + 1);
    endtask

    task automatic wait_triggers(input int have, input int want);
        int cnt = have;
        int n = 0;
        while (cnt < want && n < 3000) begin
            @(negedge clk_in);
            n++;
            if (uart_trigger_out) cnt++;
        end
        check("trigger_count_reached", cnt, want);
    endtask

    task automatic run_to_done(input int restart_at);
        int d0 = done_cnt;
        int n = 0;
        wait_uart_idle();
        start_run();
        if (restart_at > 0) begin
            wait_triggers(1, restart_at);
            start_in = 1'b1;
            @(negedge clk_in);
            start_in = 1'b0;
        end
        while (!done_out && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        check("done_seen", done_out, 1);
        check("words_sent_at_done", words_sent_out, WC);
        check("addr_at_done", bram_addr_out, 0);
        check("busy_out_at_done", busy_out, 0);
        repeat (30) @(negedge clk_in);
        check("done_once", done_cnt - d0, 1);
        check("queue_drained", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"}, bram_addr_out, 0);
        check({tag, "_byte"}, uart_byte_out, 0);
        check({tag, "_trigger"}, uart_trigger_out, 0);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_done"}, done_out, 0);
        check({tag, "_words"}, words_sent_out, 0);
    endtask

    initial begin
        int t0;
        int d0;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        mem[2] = 32'h00FF00FF;
        for (int i = 0; i < 12; i++) hold_tab[i] = 20;

        // Reset and idle behaviour
        repeat (5) @(negedge clk_in);
        check_outputs_zero("in_reset");
        rst_in = 1'b1;
        @(negedge clk_in);
        check_outputs_zero("after_reset");
        t0 = trig_total;
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (100) @(negedge clk_in);
        check("start_disabled_triggers", trig_total - t0, 0);
        check("start_disabled_busy", busy_out, 0);

        // Full run
        enable_in = 1'b1;
        run_to_done(0);

        // Backpressure on the third byte
        hold_tab[2] = 200;
        run_to_done(0);
        hold_tab[2] = 20;

        // Abort after the fifth trigger
        wait_uart_idle();
        start_run();
        wait_triggers(1, 5);
        enable_in = 1'b0;
        @(negedge clk_in);
        check("abort_busy_out", busy_out, 0);
        check("abort_addr", bram_addr_out, 0);
        check("abort_trigger", uart_trigger_out, 0);
        t0 = trig_total;
        d0 = done_cnt;
        repeat (100) @(negedge clk_in);
        check("abort_no_triggers", trig_total - t0, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_words_sent", words_sent_out, 1);
        check("abort_bytes_left", sb_q.size(), 7);
        sb_q.delete();
        enable_in = 1'b1;
        run_to_done(0);

        // start_in pulsed mid-run is ignored
        run_to_done(6);

        // Async reset while waiting on the uart
        wait_uart_idle();
        start_run();
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1 check_outputs_zero("async_reset");
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        sb_q.delete();
        run_to_done(0);

        // Random contents and uart hold times
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < WC; w++) mem[w] = $urandom;
            for (int i = 0; i < 12; i++) hold_tab[i] = int'($urandom_range(1, 30));
            run_to_done(0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
